// File: rtl/dmem_ctrl_if.sv
// Request/response bus between an initiator and the dmem_ctrl data memory.
// The initiator drives a request strobe with its command fields; the memory
// answers with ready (idle), a one-cycle ack, load data and an error flag.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, ack, rdata, err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with a fixed-latency request/ack handshake.
// A request is taken only in IDLE; valid accesses respond WAIT cycles later,
// misaligned or out-of-range ones are rejected immediately with err=1.
// Stores honour byte enables; loads return the full word.
module dmem_ctrl #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic     clk,
    input  logic     rst,
    dmem_ctrl_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            we_reg;
    logic [AW-1:0]   idx_reg;
    logic [31:0]     wdata_reg;
    logic [3:0]      be_reg;
    logic            err_reg;
    logic [31:0]     rdata_reg;

    // Storage is not touched by reset; it starts out as all zeros.
    logic [31:0]     mem [DEPTH] = '{default: '0};

    logic            accept;
    logic            addr_bad;
    logic            commit;
    logic            acc_we;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic [3:0]      lane_we;

    assign accept   = (state_reg == S_IDLE) && bus.req;
    assign addr_bad = (bus.addr[1:0] != 2'b00) || (bus.addr[31:2] >= 30'(DEPTH));

    // With WAIT=0 the access happens on the accepting edge itself, before the
    // command registers are loaded, so take the live bus fields in IDLE.
    always_comb begin
        if (state_reg == S_IDLE) begin
            acc_we    = bus.we;
            acc_idx   = bus.addr[AW+1:2];
            acc_wdata = bus.wdata;
            acc_be    = bus.be;
        end else begin
            acc_we    = we_reg;
            acc_idx   = idx_reg;
            acc_wdata = wdata_reg;
            acc_be    = be_reg;
        end
    end

    // Next-state, counter and commit decision.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.req) begin
                    if (addr_bad) begin
                        state_next = S_RESP;
                    end else if (WAIT == 0) begin
                        state_next = S_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(WAIT);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = S_RESP;
                    cnt_next   = 4'd0;
                    commit     = 1'b1;
                end else begin
                    cnt_next   = cnt_reg - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign bus.ready = (state_reg == S_IDLE);
    assign bus.ack   = (state_reg == S_RESP);
    assign bus.err   = (state_reg == S_RESP) && err_reg;
    assign bus.rdata = rdata_reg;

    // State, counter and latched command; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            err_reg   <= 1'b0;
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= bus.we;
                idx_reg   <= bus.addr[AW+1:2];
                wdata_reg <= bus.wdata;
                be_reg    <= bus.be;
                err_reg   <= addr_bad;
            end
        end
    end

    // Per-lane write strobes; a reset on the commit edge suppresses the store.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = !rst && commit && acc_we && acc_be[gi];
        end
    endgenerate

    // Byte-enabled memory write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // Registered load data: captured on a load commit, cleared on reject,
    // otherwise held (stores leave it alone).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (accept && addr_bad) begin
            rdata_reg <= '0;
        end else if (commit && !acc_we) begin
            rdata_reg <= mem[acc_idx];
        end
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL take parameter DEPTH, default 64, as the number of 32-bit data words stored.
REQ-002 The block SHALL take parameter WAIT, default 2, as the number of extra wait cycles before a valid response (range 0..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  initiator request strobe, sampled only while ready=1.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  store data; sampled with req.
REQ-009 be  input  4  store byte enables, be[i] selects wdata[8i+7:8i]; sampled with req.
REQ-010 ready  output  1  responder idle and able to accept a request.
REQ-011 ack  output  1  one-cycle response strobe.
REQ-012 rdata  output  32  load data, valid while ack=1 on a load.
REQ-013 err  output  1  qualifies ack: access rejected.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 ready SHALL be 1 in IDLE only; ack and err SHALL be 1 in RESP only (err only if the request was rejected).
REQ-016 In IDLE with req=1 at edge T, the block SHALL latch we, addr, wdata, be and leave IDLE.
REQ-017 In IDLE with req=0, the block SHALL stay in IDLE; req while ready=0 SHALL be ignored and not queued.
REQ-018 A request with addr[1:0]!=0 or addr[31:2]>=DEPTH SHALL go directly to RESP at edge T with err=1; no memory access; rdata=0.
REQ-019 A valid request with WAIT=0 SHALL go directly to RESP at edge T.
REQ-020 A valid request with WAIT>0 SHALL enter WAIT at edge T, loading the counter with WAIT.
REQ-021 In WAIT, the counter SHALL decrement each edge; the edge at which it holds 1 SHALL move to RESP.
REQ-022 ack SHALL therefore be high for exactly the cycle after edge T+WAIT for valid requests and after edge T for rejected ones.
REQ-023 A store SHALL commit on the edge entering RESP, writing only lanes with be[i]=1.
REQ-024 be=4'b0000 SHALL leave memory unchanged but still produce a normal ack with err=0.
REQ-025 A load SHALL capture the full word at addr[31:2] on the edge entering RESP, ignoring be.
REQ-026 rdata SHALL be driven onto the output during RESP and SHALL hold its value until the next load or rejected response.
REQ-027 On a store response, rdata SHALL keep its previous value.
REQ-028 RESP SHALL always return to IDLE on the next edge, so back-to-back requests are spaced WAIT+2 cycles apart (valid) or 2 cycles apart (rejected).
REQ-029 A load issued immediately after a store to the same word SHALL return the newly written data.

Reset
REQ-030 rst=1 at an edge SHALL force: state IDLE, counter 0, ready=1, ack=0, err=0, rdata=0.
REQ-031 rst SHALL take priority over req and over any state transition on the same edge.
REQ-032 Reset in WAIT SHALL discard the pending access; an uncommitted store SHALL never be written.
REQ-033 Memory contents SHALL NOT be cleared by rst; in simulation they SHALL initialise to zero at time 0.

Verification
REQ-034 WAIT=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF at edge 0 -> ready=0 for cycles 1-3, ack=1 err=0 in cycle 3 only, ready=1 from edge 4.
REQ-035 Next, load addr=0x10 -> ack in third cycle after acceptance with rdata=0xDEADBEEF; then store 0x000000AA with be=4'b0001 and reload -> 0xDEADBEAA.
REQ-036 Load addr=0x12 (misaligned) and addr=0x100 (DEPTH=64, out of range) -> ack=1 err=1 rdata=0 on the cycle after acceptance; memory unchanged.
REQ-037 Assert rst during WAIT of a store to 0x20 -> outputs return to reset values next cycle; a later load of 0x20 returns 0.
REQ-038 Hold req=1 continuously with WAIT=0 -> exactly one ack every 2 cycles, with no request accepted while ready=0.
REQ-039 Store with be=0 to 0x04 after writing 0x12345678 there -> ack err=0; reload returns 0x12345678.
